// File: rtl/wb_host_master_if.sv
// Command/response and Wishbone signal bundle for wb_host_master.
// The master modport is the host-master view; slave is the opposite side.
interface wb_host_master_if #(
    parameter int BYTE_WIDTH    = 8,
    parameter int NUM_BYTES     = 4,
    parameter int ADDRESS_WIDTH = 32
);
    localparam int DATA_WIDTH = BYTE_WIDTH * NUM_BYTES;

    logic                     cmd_valid_i;
    logic                     cmd_ready_o;
    logic [ADDRESS_WIDTH-1:0] cmd_adr_i;
    logic [DATA_WIDTH-1:0]    cmd_dat_i;
    logic [NUM_BYTES-1:0]     cmd_sel_i;
    logic                     cmd_we_i;

    logic                     rsp_valid_o;
    logic                     rsp_ready_i;
    logic [DATA_WIDTH-1:0]    rsp_dat_o;
    logic                     rsp_err_o;

    logic [ADDRESS_WIDTH-1:0] wb_adr_o;
    logic [DATA_WIDTH-1:0]    wb_dat_o;
    logic [NUM_BYTES-1:0]     wb_sel_o;
    logic                     wb_we_o;
    logic                     wb_cyc_o;
    logic                     wb_stb_o;
    logic                     wb_ack_i;
    logic [DATA_WIDTH-1:0]    wb_dat_i;

    modport master (
        input  cmd_valid_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, cmd_we_i,
        input  rsp_ready_i, wb_ack_i, wb_dat_i,
        output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
    );

    modport slave (
        output cmd_valid_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, cmd_we_i,
        output rsp_ready_i, wb_ack_i, wb_dat_i,
        input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
    );
endinterface

// File: rtl/wb_host_master.sv
// Single-outstanding Wishbone B4 classic-cycle initiator with valid/ready command/response ports.
// Optional ack timeout is enabled by defining WB_HOST_MASTER_TIMEOUT_EN.
module wb_host_master #(
    parameter int BYTE_WIDTH    = 8,
    parameter int NUM_BYTES     = 4,
    parameter int ADDRESS_WIDTH = 32,
    parameter int TIMEOUT       = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    wb_host_master_if.master bus
);
    localparam int DATA_WIDTH = BYTE_WIDTH * NUM_BYTES;

    typedef enum logic [1:0] {IDLE, BUS, RSP} state_t;

    state_t                   state_q,     state_d;
    logic                     cmd_ready_q, cmd_ready_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]    rsp_dat_q,   rsp_dat_d;
    logic                     wb_cyc_q,    wb_cyc_d;
    logic [ADDRESS_WIDTH-1:0] wb_adr_q,    wb_adr_d;
    logic [DATA_WIDTH-1:0]    wb_dat_q,    wb_dat_d;
    logic [NUM_BYTES-1:0]     wb_sel_q,    wb_sel_d;
    logic                     wb_we_q,     wb_we_d;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("wb_host_master: TIMEOUT must be at least 1");
    end

`ifdef WB_HOST_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             rsp_err_q, rsp_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        wb_cyc_d    = wb_cyc_q;
        wb_adr_d    = wb_adr_q;
        wb_dat_d    = wb_dat_q;
        wb_sel_d    = wb_sel_q;
        wb_we_d     = wb_we_q;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                // ready is registered, so the first edge after reset release only raises it
                if (bus.cmd_valid_i && cmd_ready_q) begin
                    state_d     = BUS;
                    cmd_ready_d = 1'b0;
                    wb_cyc_d    = 1'b1;
                    wb_adr_d    = bus.cmd_adr_i;
                    wb_dat_d    = bus.cmd_dat_i;
                    wb_sel_d    = bus.cmd_sel_i;
                    wb_we_d     = bus.cmd_we_i;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            BUS: begin
                if (bus.wb_ack_i) begin
                    state_d     = RSP;
                    wb_cyc_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = wb_we_q ? '0 : bus.wb_dat_i;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                    // this edge would bring the count to TIMEOUT: abort the cycle
                    state_d     = RSP;
                    wb_cyc_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    tmo_cnt_d   = tmo_cnt_q + TMO_W'(1);
`endif
                end
            end
            RSP: begin
                if (bus.rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                wb_cyc_d    = 1'b0;
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            wb_cyc_q    <= 1'b0;
            wb_adr_q    <= '0;
            wb_dat_q    <= '0;
            wb_sel_q    <= '0;
            wb_we_q     <= 1'b0;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            wb_cyc_q    <= wb_cyc_d;
            wb_adr_q    <= wb_adr_d;
            wb_dat_q    <= wb_dat_d;
            wb_sel_q    <= wb_sel_d;
            wb_we_q     <= wb_we_d;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign bus.cmd_ready_o = cmd_ready_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_dat_o   = rsp_dat_q;
    assign bus.wb_cyc_o    = wb_cyc_q;
    assign bus.wb_stb_o    = wb_cyc_q;
    assign bus.wb_adr_o    = wb_adr_q;
    assign bus.wb_dat_o    = wb_dat_q;
    assign bus.wb_sel_o    = wb_sel_q;
    assign bus.wb_we_o     = wb_we_q;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
    assign bus.rsp_err_o   = rsp_err_q;
`else
    assign bus.rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_host_master.sv
// Scoreboard bench for wb_host_master: random slave wait states and response back-pressure,
// expected responses come from a byte-lane memory model.
module tb_wb_host_master;
    localparam int BW  = 8;
    localparam int NB  = 4;
    localparam int AW  = 32;
    localparam int TMO = 8;

    typedef struct {
        logic [31:0] dat;
        logic        err;
    } rsp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // command side stimulus
    logic        cmd_valid = 1'b0;
    logic [31:0] cmd_adr   = '0;
    logic [31:0] cmd_dat   = '0;
    logic [3:0]  cmd_sel   = '0;
    logic        cmd_we    = 1'b0;
    logic        rsp_ready = 1'b0;
    int          rdy_mode  = 1;   // 0 random, 1 always ready, 2 held low

    // slave model
    logic        slv_ack  = 1'b0;
    logic        spur_ack = 1'b0;
    logic [31:0] slv_rdat = '0;
    bit          slave_en = 1'b1;
    int          slv_cnt = 0, slv_target = 0, wait_max = 0;

    logic [31:0] slv_mem [int unsigned];
    logic [31:0] ref_mem [int unsigned];
    rsp_t        sb_q [$];

    // command currently owning the bus
    logic [31:0] cur_adr = '0, cur_dat = '0;
    logic [3:0]  cur_sel = '0;
    logic        cur_we  = 1'b0;
    bit          prev_ack = 1'b0;
    int          rsp_no   = 0;

    wb_host_master_if #(.BYTE_WIDTH(BW), .NUM_BYTES(NB), .ADDRESS_WIDTH(AW)) bus ();

    wb_host_master #(
        .BYTE_WIDTH(BW), .NUM_BYTES(NB), .ADDRESS_WIDTH(AW), .TIMEOUT(TMO)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .bus        (bus)
    );

    assign bus.cmd_valid_i = cmd_valid;
    assign bus.cmd_adr_i   = cmd_adr;
    assign bus.cmd_dat_i   = cmd_dat;
    assign bus.cmd_sel_i   = cmd_sel;
    assign bus.cmd_we_i    = cmd_we;
    assign bus.rsp_ready_i = rsp_ready;
    assign bus.wb_ack_i    = slv_ack | spur_ack;
    assign bus.wb_dat_i    = slv_rdat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdat,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = wdat[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : 32'h0;
    endfunction

    // Registered-ack slave: ack is raised target+1 cycles after it first sees the strobe.
    always @(posedge clk) begin
        #1;
        if (!slave_en || !rst_n) begin
            slv_ack = 1'b0;
            slv_cnt = 0;
        end else if (slv_ack) begin
            slv_ack    = 1'b0;
            slv_cnt    = 0;
            slv_target = $urandom_range(wait_max, 0);
        end else if (bus.wb_cyc_o && bus.wb_stb_o) begin
            slv_cnt++;
            if (slv_cnt >= slv_target + 2) begin
                slv_ack = 1'b1;
                if (bus.wb_we_o)
                    slv_mem[bus.wb_adr_o] = merge(slv_rd(bus.wb_adr_o), bus.wb_dat_o, bus.wb_sel_o);
                else
                    slv_rdat = slv_rd(bus.wb_adr_o);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       rsp_ready = 1'($urandom_range(1, 0));
            1:       rsp_ready = 1'b1;
            default: rsp_ready = 1'b0;
        endcase
    end

    // Response scoreboard: the handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid_o && rsp_ready) begin
            if (sb_q.size() == 0) begin
                chk("rsp_unexpected", 64'(bus.rsp_valid_o), 64'd0);
            end else begin
                rsp_t e;
                e = sb_q.pop_front();
                rsp_no++;
                $display("rsp %0d: dat=%08h err=%0b (model dat=%08h err=%0b)",
                         rsp_no, bus.rsp_dat_o, bus.rsp_err_o, e.dat, e.err);
                chk("rsp_dat", 64'(bus.rsp_dat_o), 64'(e.dat));
                chk("rsp_err", 64'(bus.rsp_err_o), 64'(e.err));
            end
        end
    end

    // Bus monitor: stable address phase and a single strobe per command.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_ack) chk("cyc_drop_after_ack", 64'(bus.wb_cyc_o), 64'd0);
            if (bus.wb_cyc_o) begin
                chk("stb_eq_cyc", 64'(bus.wb_stb_o), 64'd1);
                chk("bus_adr", 64'(bus.wb_adr_o), 64'(cur_adr));
                chk("bus_dat", 64'(bus.wb_dat_o), 64'(cur_dat));
                chk("bus_sel", 64'(bus.wb_sel_o), 64'(cur_sel));
                chk("bus_we",  64'(bus.wb_we_o),  64'(cur_we));
            end
            prev_ack = bus.wb_cyc_o && bus.wb_ack_i;
        end else begin
            prev_ack = 1'b0;
        end
    end

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic do_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic err_exp);
        rsp_t e;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.cmd_ready_o) begin
                cur_adr = adr; cur_dat = dat; cur_sel = sel; cur_we = we;
                if (err_exp) begin
                    e.dat = 32'h0; e.err = 1'b1;
                end else if (we) begin
                    ref_mem[adr] = merge(ref_rd(adr), dat, sel);
                    e.dat = 32'h0; e.err = 1'b0;
                end else begin
                    e.dat = ref_rd(adr); e.err = 1'b0;
                end
                sb_q.push_back(e);
                @(posedge clk);
                #1;
                cmd_valid = 1'b0;
                return;
            end
        end
        chk("cmd_accept_timeout", 64'd0, 64'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2000; i++) begin
            if (sb_q.size() == 0) return;
            @(negedge clk);
        end
        chk("drain_timeout", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #400us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        // reset values
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 64'(bus.cmd_ready_o), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        chk("rst_rsp_err",   64'(bus.rsp_err_o),   64'd0);
        chk("rst_rsp_dat",   64'(bus.rsp_dat_o),   64'd0);
        chk("rst_cyc",       64'(bus.wb_cyc_o),    64'd0);
        chk("rst_stb",       64'(bus.wb_stb_o),    64'd0);
        chk("rst_we",        64'(bus.wb_we_o),     64'd0);
        chk("rst_adr",       64'(bus.wb_adr_o),    64'd0);
        chk("rst_dat",       64'(bus.wb_dat_o),    64'd0);
        chk("rst_sel",       64'(bus.wb_sel_o),    64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_release", 64'(bus.cmd_ready_o), 64'd1);

        // directed write with latency and pulse-shape checks
        do_cmd(1'b1, 32'h10, 32'h12345678, 4'hF, 1'b0);
        @(negedge clk);
        chk("w_cyc_c1", 64'(bus.wb_cyc_o), 64'd1);
        chk("w_we_c1", 64'(bus.wb_we_o), 64'd1);
        chk("w_valid_c1", 64'(bus.rsp_valid_o), 64'd0);
        @(negedge clk);
        chk("w_cyc_c2", 64'(bus.wb_cyc_o), 64'd1);
        chk("w_valid_c2", 64'(bus.rsp_valid_o), 64'd0);
        @(negedge clk);
        chk("w_cyc_c3", 64'(bus.wb_cyc_o), 64'd0);
        chk("w_valid_c3", 64'(bus.rsp_valid_o), 64'd1);
        drain();

        @(posedge clk); #1;
        do_cmd(1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
        do_cmd(1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, 1'b0);
        drain();

        // read back under response back-pressure; next command waits for the handshake
        rdy_mode = 2;
        @(posedge clk); #1;
        do_cmd(1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid_o) break;
        end
        chk("hold_rsp_arrived", 64'(bus.rsp_valid_o), 64'd1);
        @(posedge clk); #1;
        fork
            do_cmd(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("hold_valid", 64'(bus.rsp_valid_o), 64'd1);
                    chk("hold_dat", 64'(bus.rsp_dat_o), 64'h12BB56DD);
                    chk("hold_cmd_ready", 64'(bus.cmd_ready_o), 64'd0);
                end
                rdy_mode = 1;
                @(negedge clk);
                chk("hs_cmd_ready", 64'(bus.cmd_ready_o), 64'd0);
                chk("hs_valid", 64'(bus.rsp_valid_o), 64'd1);
                @(negedge clk);
                chk("post_hs_cmd_ready", 64'(bus.cmd_ready_o), 64'd1);
                chk("post_hs_valid", 64'(bus.rsp_valid_o), 64'd0);
            end
        join
        drain();

`ifdef WB_HOST_MASTER_TIMEOUT_EN
        // slave never acks: abort after TMO bus cycles, then a normal read
        slave_en = 1'b0;
        @(posedge clk); #1;
        do_cmd(1'b0, 32'h40, 32'h0, 4'hF, 1'b1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.wb_cyc_o) n++;
            else break;
        end
        chk("tmo_cyc_cycles", 64'(n), 64'(TMO));
        drain();
        slave_en = 1'b1;
        @(posedge clk); #1;
        do_cmd(1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
        drain();
`endif

        // reset in the middle of a bus cycle, spurious ack in IDLE afterwards
        slave_en = 1'b0;
        @(posedge clk); #1;
        do_cmd(1'b0, 32'h30, 32'h0, 4'hF, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cyc", 64'(bus.wb_cyc_o), 64'd0);
        chk("arst_stb", 64'(bus.wb_stb_o), 64'd0);
        chk("arst_cmd_ready", 64'(bus.cmd_ready_o), 64'd0);
        sb_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        spur_ack = 1'b1;
        @(posedge clk); #1;
        spur_ack = 1'b0;
        n = 0;
        repeat (3) begin
            @(negedge clk);
            chk("spur_no_valid", 64'(bus.rsp_valid_o), 64'd0);
            chk("spur_no_cyc", 64'(bus.wb_cyc_o), 64'd0);
            chk("spur_cmd_ready", 64'(bus.cmd_ready_o), 64'd1);
        end
        slave_en = 1'b1;

        // random traffic
        wait_max = 4;
        rdy_mode = 0;
        @(posedge clk); #1;
        for (int t = 0; t < 100; t++) begin
            logic        we;
            logic [31:0] adr;
            we  = 1'($urandom_range(1, 0));
            adr = 32'($urandom_range(7, 0)) * 32'd4;
            do_cmd(we, adr, $urandom, 4'($urandom_range(15, 0)), 1'b0);
        end
        rdy_mode = 1;
        drain();
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_host_master.md
# wb_host_master

Single-outstanding Wishbone classic-cycle initiator. It accepts one read or write command on a valid/ready command port and drives a Wishbone B4 classic cycle to a slave such as the team's on-chip RAM. It returns the read data, or a write completion, on a valid/ready response port. It bridges test sequencers, debug and boot-loader logic onto the Wishbone fabric.

## Interface
Parameters:
- BYTE_WIDTH, 8, bits per byte lane
- NUM_BYTES, 4, byte lanes per data word
- ADDRESS_WIDTH, 32, Wishbone address width (byte address)
- TIMEOUT, 255, cycles to wait for ack before aborting (only used with WB_HOST_MASTER_TIMEOUT_EN); must be ≥1

Ports:
- wb_clk_i  in  1  clock, all logic on rising edge
- wb_rst_n_i  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid & ready
- cmd_adr_i  in  ADDRESS_WIDTH  byte address
- cmd_dat_i  in  BYTE_WIDTH*NUM_BYTES  write data
- cmd_sel_i  in  NUM_BYTES  byte enables
- cmd_we_i  in  1  1 = write, 0 = read
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid & ready
- rsp_dat_o  out  BYTE_WIDTH*NUM_BYTES  read data (0 for writes)
- rsp_err_o  out  1  transaction timed out
- wb_adr_o  out  ADDRESS_WIDTH  Wishbone address
- wb_dat_o  out  BYTE_WIDTH*NUM_BYTES  Wishbone write data
- wb_sel_o  out  NUM_BYTES  Wishbone byte select
- wb_we_o  out  1  Wishbone write enable
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_ack_i  in  1  Wishbone acknowledge
- wb_dat_i  in  BYTE_WIDTH*NUM_BYTES  Wishbone read data

## Operation
- FSM states: IDLE, BUS, RSP. All outputs are registered or decoded from the state register only; there are no combinational paths from inputs to outputs.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i: latch adr/dat/sel/we into wb_*_o and enter BUS.
- BUS:
  - wb_cyc_o = wb_stb_o = 1; adr/dat/sel/we are held stable.
  - On wb_ack_i sampled high: capture wb_dat_i into rsp_dat_o on reads, or capture 0 on writes. Set rsp_err_o = 0 and enter RSP.
- RSP:
  - rsp_valid_o = 1; rsp_dat_o and rsp_err_o are held.
  - On rsp_ready_i: go to IDLE.
- wb_cyc_o/wb_stb_o are high only in BUS and drop on the edge that samples ack, so there is never a back-to-back strobe.
- wb_we_o, wb_adr_o, wb_sel_o and wb_dat_o keep their last value outside BUS.
- wb_ack_i in IDLE or RSP is ignored: no state change, no data capture.
- cmd_sel_i = 0 is passed through unchanged. The slave decides what to do with it.

## Timing
- Reset values: state IDLE, cmd_ready_o 0 during reset and 1 after release, rsp_valid_o 0, rsp_err_o 0, rsp_dat_o 0, wb_cyc_o 0, wb_stb_o 0, wb_we_o 0, wb_adr_o 0, wb_dat_o 0, wb_sel_o 0.
- Command accepted at edge N → cyc/stb high after edge N.
- A slave asserting ack at edge N+1+k is sampled at edge N+1+k → rsp_valid_o is high after that edge.
  - Zero-wait slave: response 2 cycles after acceptance.
  - Registered-ack slave: response 3 cycles after acceptance.
- Response handshake at edge M → cmd_ready_o high after M. The earliest next acceptance is edge M+1.
- Throughput is at most 1 transaction per 3 cycles.
- Reset asserted mid-operation clears cyc/stb immediately (asynchronously); any pending response is discarded.

## Configuration
- WB_HOST_MASTER_TIMEOUT_EN defined:
  - A cycle counter of $clog2(TIMEOUT+1) bits clears on entry to BUS and increments each BUS cycle without ack.
  - When it reaches TIMEOUT with no ack, cyc/stb drop and the FSM enters RSP with rsp_err_o = 1 and rsp_dat_o = 0.
  - Ack sampled on the same edge as the timeout wins: normal completion, err = 0.
- Not defined: no counter; BUS waits indefinitely; rsp_err_o is tied 0.

## Test plan
- Write 0x12345678 to adr 0x10, sel 4'hF, registered-ack slave model → exactly one cyc/stb pulse of 2 cycles with stable adr/dat/sel and we=1; rsp_valid_o 3 cycles after acceptance with rsp_dat_o = 0 and rsp_err_o = 0.
- Read back adr 0x10 → rsp_dat_o = 0x12345678. Then write 0xAABBCCDD with sel 4'b0101 and read again → 0x12BB56DD.
- Hold rsp_ready_i low for 5 cycles → rsp_valid_o and rsp_dat_o stay stable; cmd_ready_o stays 0; a second command is not accepted until the cycle after the response handshake.
- Slave never acks, TIMEOUT = 8, macro defined → cyc/stb drop after 8 BUS cycles; response has rsp_err_o = 1 and rsp_dat_o = 0; a following normal read succeeds with err = 0.
- Assert wb_rst_n_i low while in BUS, release 3 cycles later with a spurious wb_ack_i pulse in IDLE → cyc/stb are 0 asynchronously; no rsp_valid_o; cmd_ready_o = 1 after release.
- 100 random read/write commands with random slave wait states 0–4 and random rsp_ready_i → scoreboard matches all read data; at most one cyc/stb cycle is in flight at any time.
